ps2_scancode_tracker: RTL and testbench

//  Sits directly downstream of KeyboardPS2_Controller; consumes its received_data/received_data_en byte stream.

---
 rtl/ps2_scancode_tracker.sv | 164 ++++++++++++++++
 tb/tb_ps2_scancode_tracker.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_tracker.sv
// PS/2 Set-2 scan-code sequence parser: turns the raw byte stream into key events
// and tracks held/pressed state for space, enter, '1' and '2'.
module ps2_scancode_tracker #(
    parameter int TIMEOUT_CYCLES = 500000,
    parameter int TW             = 19
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] received_data,
    input  logic       received_data_en,
    output logic       event_valid,
    output logic [7:0] event_code,
    output logic       event_ext,
    output logic       event_break,
    output logic       space_down,
    output logic       enter_down,
    output logic       one_down,
    output logic       two_down,
    output logic       space_hit,
    output logic       enter_hit,
    output logic       one_hit,
    output logic       two_hit
);

    typedef enum logic [2:0] {IDLE, PRE_E0, PRE_F0, PRE_E0F0, SKIP} state_t;

    state_t        state_q, state_d;
    logic [2:0]    skip_q, skip_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          ev_valid_q, ev_valid_d;
    logic [7:0]    ev_code_q, ev_code_d;
    logic          ev_ext_q, ev_ext_d;
    logic          ev_brk_q, ev_brk_d;
    // bit order: space, enter, one, two
    logic [3:0]    down_q, down_d;
    logic [3:0]    hit_q, hit_d;

    logic          fire, fire_ext, fire_brk, bat;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q    <= IDLE;
            skip_q     <= '0;
            tmo_q      <= '0;
            ev_valid_q <= 1'b0;
            ev_code_q  <= '0;
            ev_ext_q   <= 1'b0;
            ev_brk_q   <= 1'b0;
            down_q     <= '0;
            hit_q      <= '0;
        end else begin
            state_q    <= state_d;
            skip_q     <= skip_d;
            tmo_q      <= tmo_d;
            ev_valid_q <= ev_valid_d;
            ev_code_q  <= ev_code_d;
            ev_ext_q   <= ev_ext_d;
            ev_brk_q   <= ev_brk_d;
            down_q     <= down_d;
            hit_q      <= hit_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        skip_d   = skip_q;
        tmo_d    = tmo_q;
        fire     = 1'b0;
        fire_ext = 1'b0;
        fire_brk = 1'b0;
        bat      = 1'b0;
        if (received_data_en) begin
            tmo_d = '0;
            case (state_q)
                IDLE: begin
                    case (received_data)
                        8'hE0: state_d = PRE_E0;
                        8'hF0: state_d = PRE_F0;
                        8'hE1: begin
                            state_d = SKIP;
                            skip_d  = 3'd7;
                        end
                        8'hAA: bat = 1'b1;
                        8'h00, 8'hEE, 8'hFA, 8'hFE, 8'hFF: ;
                        default: fire = 1'b1;
                    endcase
                end
                PRE_E0: begin
                    case (received_data)
                        8'hF0: state_d = PRE_E0F0;
                        8'hE0: ;
                        8'hE1, 8'hAA, 8'hFA, 8'hFE: state_d = IDLE;
                        default: begin
                            fire     = 1'b1;
                            fire_ext = 1'b1;
                            state_d  = IDLE;
                        end
                    endcase
                end
                PRE_F0, PRE_E0F0: begin
                    state_d = IDLE;
                    if (received_data != 8'hE0 && received_data != 8'hE1 &&
                        received_data != 8'hF0) begin
                        fire     = 1'b1;
                        fire_brk = 1'b1;
                        fire_ext = (state_q == PRE_E0F0);
                    end
                end
                SKIP: begin
                    skip_d = skip_q - 3'd1;
                    if (skip_q == 3'd1) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE) begin
            // abandon a sequence whose next byte never arrived
            if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                state_d = IDLE;
                tmo_d   = '0;
                skip_d  = '0;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
    end

    always_comb begin
        ev_valid_d = fire;
        ev_code_d  = fire ? received_data : ev_code_q;
        ev_ext_d   = fire ? fire_ext : ev_ext_q;
        ev_brk_d   = fire ? fire_brk : ev_brk_q;
        down_d     = down_q;
        if (bat) begin
            down_d = '0;
        end else if (fire) begin
            if (!fire_ext) begin
                case (received_data)
                    8'h29: down_d[0] = ~fire_brk;
                    8'h5A: down_d[1] = ~fire_brk;
                    8'h16: down_d[2] = ~fire_brk;
                    8'h1E: down_d[3] = ~fire_brk;
                    default: ;
                endcase
            end else if (received_data == 8'h5A) begin
                down_d[1] = ~fire_brk;
            end
        end
        hit_d = down_d & ~down_q;
    end

    assign event_valid = ev_valid_q;
    assign event_code  = ev_code_q;
    assign event_ext   = ev_ext_q;
    assign event_break = ev_brk_q;
    assign space_down  = down_q[0];
    assign enter_down  = down_q[1];
    assign one_down    = down_q[2];
    assign two_down    = down_q[3];
    assign space_hit   = hit_q[0];
    assign enter_hit   = hit_q[1];
    assign one_hit     = hit_q[2];
    assign two_hit     = hit_q[3];

endmodule

// File: tb/tb_ps2_scancode_tracker.sv
// Bench for ps2_scancode_tracker: directed scenarios plus random byte traffic,
// every cycle compared against a prefix-flag reference model of the PS/2 rules.
module tb_ps2_scancode_tracker;

    localparam int TMO = 100;

    logic       CLOCK_50 = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] received_data = '0;
    logic       received_data_en = 1'b0;
    logic       event_valid, event_ext, event_break;
    logic [7:0] event_code;
    logic       space_down, enter_down, one_down, two_down;
    logic       space_hit, enter_hit, one_hit, two_hit;

    ps2_scancode_tracker #(.TIMEOUT_CYCLES(TMO), .TW(8)) dut (
        .CLOCK_50(CLOCK_50), .reset(reset),
        .received_data(received_data), .received_data_en(received_data_en),
        .event_valid(event_valid), .event_code(event_code),
        .event_ext(event_ext), .event_break(event_break),
        .space_down(space_down), .enter_down(enter_down),
        .one_down(one_down), .two_down(two_down),
        .space_hit(space_hit), .enter_hit(enter_hit),
        .one_hit(one_hit), .two_hit(two_hit)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int checks = 0;
    int errors = 0;
    int ev_seen = 0;
    int hit_seen = 0;

    // reference model: pending prefixes, skip count, held keys
    bit         m_e0, m_f0;
    int         m_skip;
    int         m_gap;
    bit         m_down [4];
    bit         m_hit [4];
    bit         m_valid;
    logic [7:0] m_code;
    bit         m_ext, m_brk;

    function automatic int key_index(logic [7:0] code, bit ext);
        if (code == 8'h5A) return 1;
        if (ext) return -1;
        if (code == 8'h29) return 0;
        if (code == 8'h16) return 2;
        if (code == 8'h1E) return 3;
        return -1;
    endfunction

    function automatic void m_clear_seq();
        m_e0 = 0; m_f0 = 0; m_skip = 0; m_gap = 0;
    endfunction

    function automatic void m_emit(logic [7:0] code, bit ext, bit brk);
        int k;
        m_valid = 1; m_code = code; m_ext = ext; m_brk = brk;
        k = key_index(code, ext);
        if (k >= 0) begin
            if (!brk && !m_down[k]) m_hit[k] = 1;
            m_down[k] = !brk;
        end
        m_clear_seq();
    endfunction

    function automatic void m_byte(logic [7:0] b);
        if (m_skip > 0) begin
            m_skip--;
        end else if (m_f0) begin
            if (b == 8'hE0 || b == 8'hE1 || b == 8'hF0) m_clear_seq();
            else m_emit(b, m_e0, 1);
        end else if (m_e0) begin
            if (b == 8'hF0) m_f0 = 1;
            else if (b == 8'hE0) ;
            else if (b == 8'hE1 || b == 8'hAA || b == 8'hFA || b == 8'hFE) m_clear_seq();
            else m_emit(b, 1, 0);
        end else begin
            case (b)
                8'hE0: m_e0 = 1;
                8'hF0: m_f0 = 1;
                8'hE1: m_skip = 7;
                8'hAA: for (int i = 0; i < 4; i++) m_down[i] = 0;
                8'h00, 8'hEE, 8'hFA, 8'hFE, 8'hFF: ;
                default: m_emit(b, 0, 0);
            endcase
        end
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic en, input logic [7:0] d);
        reset = r; received_data_en = en; received_data = d;
        @(posedge CLOCK_50);
        m_valid = 0;
        for (int i = 0; i < 4; i++) m_hit[i] = 0;
        if (r) begin
            m_clear_seq();
            for (int i = 0; i < 4; i++) m_down[i] = 0;
            m_code = 0; m_ext = 0; m_brk = 0;
        end else if (en) begin
            m_gap = 0;
            m_byte(d);
        end else if (m_e0 || m_f0 || m_skip > 0) begin
            m_gap++;
            if (m_gap == TMO) m_clear_seq();
        end
        #1;
        reset = 1'b0; received_data_en = 1'b0;
        ev_seen  += int'(event_valid);
        hit_seen += int'(space_hit) + int'(enter_hit) + int'(one_hit) + int'(two_hit);
        chk("event_valid", {7'd0, event_valid}, {7'd0, m_valid});
        chk("event_code", event_code, m_code);
        chk("event_ext", {7'd0, event_ext}, {7'd0, m_ext});
        chk("event_break", {7'd0, event_break}, {7'd0, m_brk});
        chk("down", {4'd0, two_down, one_down, enter_down, space_down},
            {4'd0, m_down[3], m_down[2], m_down[1], m_down[0]});
        chk("hit", {4'd0, two_hit, one_hit, enter_hit, space_hit},
            {4'd0, m_hit[3], m_hit[2], m_hit[1], m_hit[0]});
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        step(1'b0, 1'b1, b);
        repeat (gap) step(1'b0, 1'b0, 8'h00);
    endtask

    logic [7:0] pool [12] = '{8'h29, 8'h5A, 8'h16, 8'h1E, 8'hF0, 8'hE0,
                              8'hE1, 8'hAA, 8'h12, 8'h00, 8'hFA, 8'h5A};

    initial begin
        int e0, h0, g;
        repeat (3) step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);

        // 1: space make, break
        send(8'h29, 5);
        chk("t1_space_held", {7'd0, space_down}, 8'd1);
        send(8'hF0, 5);
        send(8'h29, 3);
        chk("t1_space_released", {7'd0, space_down}, 8'd0);

        // 2: extended enter, then typematic repeat
        send(8'hE0, 2); send(8'h5A, 2);
        send(8'hE0, 2); send(8'hF0, 2); send(8'h5A, 2);
        e0 = ev_seen; h0 = hit_seen;
        send(8'h5A, 2); send(8'h5A, 2); send(8'h5A, 2);
        chk("t2_repeat_events", 8'(ev_seen - e0), 8'd3);
        chk("t2_repeat_hits", 8'(hit_seen - h0), 8'd1);

        // 3: stale F0 abandoned by timeout
        send(8'hF0, TMO + 10);
        send(8'h16, 2);
        chk("t3_one_held", {7'd0, one_down}, 8'd1);

        // 4: Pause sequence dropped
        e0 = ev_seen;
        foreach (pool[i]) if (i < 0) ;
        send(8'hE1, 1); send(8'h14, 1); send(8'h77, 1); send(8'hE1, 1);
        send(8'hF0, 1); send(8'h14, 1); send(8'hF0, 1); send(8'h77, 1);
        send(8'h1E, 2);
        chk("t4_pause_events", 8'(ev_seen - e0), 8'd1);

        // 5: BAT releases all; reset beats a strobe in PRE_F0
        e0 = ev_seen;
        send(8'hAA, 2);
        chk("t5_bat_events", 8'(ev_seen - e0), 8'd0);
        send(8'h29, 1);
        send(8'hF0, 1);
        step(1'b1, 1'b1, 8'h29);
        step(1'b0, 1'b0, 8'h00);

        // 6: back-to-back strobes
        send(8'h29, 0); send(8'hF0, 0); send(8'h29, 0); send(8'h29, 2);

        // random traffic, with occasional stale sequences
        for (int n = 0; n < 600; n++) begin
            g = ($urandom_range(0, 40) == 0) ? TMO + $urandom_range(0, 20)
                                             : $urandom_range(0, 4);
            send(pool[$urandom_range(0, 11)], g);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
